scroll_ctrl: RTL and testbench

SCROLL_CTRL -- requirements
Module: scroll_ctrl

---
 rtl/disp_pkg.sv | 13 +
 rtl/tick_gen.sv | 21 ++
 rtl/scroll_ctrl.sv | 73 +++++++
 tb/tb_scroll_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared display-rotation constants, FSM encoding and position helpers
package disp_pkg;
  localparam int NUM_POS = 5;
  localparam int SEL_W = 3;
  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_e;
  function automatic logic [SEL_W-1:0] next_pos(input logic [SEL_W-1:0] cur, input logic rev);
    return rev ? ((cur == '0) ? SEL_W'(NUM_POS - 1) : cur - SEL_W'(1))
               : ((cur >= SEL_W'(NUM_POS - 1)) ? '0 : cur + SEL_W'(1));
  endfunction
  function automatic logic [SEL_W-1:0] clamp_pos(input logic [SEL_W-1:0] v);
    return (v >= SEL_W'(NUM_POS)) ? '0 : v;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler issuing a one-cycle tick every TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: rotating 5-position display select with auto-scroll, step key and load
module scroll_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             dir,
  input  logic             step_key,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] selc,
  output logic             adv,
  output logic             running
);
  logic run_s1_q, run_s2_q, key_s1_q, key_s2_q, key_prev_q;
  state_e state_q, state_d;
  logic [SEL_W-1:0] selc_q, selc_d;
  logic adv_q, adv_d, running_q, running_d;
  logic tick, step_ev, clr, en;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );
  // Prescaler restarts on load and on PAUSE->RUN, so the first tick lands TICK_DIV cycles later
  always_comb begin
    en = state_q == RUN;
    step_ev = key_s2_q & ~key_prev_q;
    state_d = run_s2_q ? RUN : PAUSE;
    clr = load || (state_q == PAUSE && run_s2_q);
    running_d = state_d == RUN;
    selc_d = selc_q;
    adv_d = 1'b0;
    if (load) begin
      selc_d = clamp_pos(load_val);
      adv_d = selc_d != selc_q;
    end else if ((state_q == RUN && tick) || (state_q == PAUSE && step_ev)) begin
      selc_d = next_pos(selc_q, dir);
      adv_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      key_s1_q <= 1'b0;
      key_s2_q <= 1'b0;
      key_prev_q <= 1'b0;
      state_q <= PAUSE;
      selc_q <= '0;
      adv_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      run_s1_q <= run;
      run_s2_q <= run_s1_q;
      key_s1_q <= step_key;
      key_s2_q <= key_s1_q;
      key_prev_q <= key_s2_q;
      state_q <= state_d;
      selc_q <= selc_d;
      adv_q <= adv_d;
      running_q <= running_d;
    end
  end
  assign selc = selc_q;
  assign adv = adv_q;
  assign running = running_q;
endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: directed scoreboard bench for scroll_ctrl with TICK_DIV=4
module tb_scroll_ctrl;
  localparam int TD = 4;
  logic clk = 1'b0, rst_n = 1'b1, run = 1'b0, dir = 1'b0, step_key = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] selc;
  logic adv, running;
  int n_chk = 0, n_fail = 0, cyc = 0, t = 0;
  typedef struct {
    logic [2:0] val;
    int at;
  } exp_t;
  exp_t sb[$];
  scroll_ctrl #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .dir     (dir),
    .step_key(step_key),
    .load    (load),
    .load_val(load_val),
    .selc    (selc),
    .adv     (adv),
    .running (running)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [2:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at = at;
    sb.push_back(e);
  endtask
  // Every adv pulse must match the oldest expected advance, both in value and in cycle
  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check("selc_range", 32'(selc <= 3'd4), 1);
      while (sb.size() > 0 && sb[0].at < cyc) begin
        check("missed_adv", cyc, sb[0].at);
        void'(sb.pop_front());
      end
      if (adv) begin
        if (sb.size() == 0) check("spurious_adv", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("adv_selc", selc, e.val);
          check("adv_cycle", cyc, e.at);
        end
      end
    end
  endtask
  task automatic wait_to(input int c);
    if (c > cyc) step(c - cyc);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_selc", selc, 0);
    check("reset_adv", adv, 0);
    check("reset_running", running, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("idle_selc", selc, 0);
    t = cyc;
    run = 1'b1;
    for (int k = 1; k <= 5; k++) push(3'(k % 5), t + 3 + TD * k);
    step(3);
    check("running_on", running, 1);
    wait_to(t + 3 + TD * 5);
    check("fwd_sb_empty", sb.size(), 0);
    t = cyc;
    run = 1'b0;
    wait_to(t + 8);
    check("running_off", running, 0);
    dir = 1'b1;
    for (int p = 0; p < 3; p++) begin
      t = cyc;
      step_key = 1'b1;
      push(3'(4 - p), t + 3);
      step(10);
      step_key = 1'b0;
      step(10);
    end
    check("step_sb_empty", sb.size(), 0);
    check("step_selc", selc, 2);
    t = cyc;
    run = 1'b1;
    push(3'd1, t + 7);
    wait_to(t + 3);
    step_key = 1'b1;
    step(6);
    step_key = 1'b0;
    wait_to(t + 10);
    check("run_key_sb_empty", sb.size(), 0);
    check("run_key_selc", selc, 1);
    load = 1'b1;
    load_val = 3'd6;
    push(3'd0, t + 11);
    step(1);
    load = 1'b0;
    push(3'd4, t + 15);
    wait_to(t + 15);
    load = 1'b1;
    load_val = 3'd3;
    push(3'd3, t + 16);
    step(1);
    load = 1'b0;
    push(3'd2, t + 20);
    wait_to(t + 20);
    load = 1'b1;
    load_val = 3'd2;
    step(1);
    load = 1'b0;
    check("load_same_selc", selc, 2);
    push(3'd1, t + 25);
    wait_to(t + 25);
    load = 1'b1;
    load_val = 3'd3;
    push(3'd3, t + 26);
    step(1);
    load = 1'b0;
    step(2);
    check("pre_reset_selc", selc, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_selc", selc, 0);
    check("async_rst_adv", adv, 0);
    check("async_rst_running", running, 0);
    step(2);
    rst_n = 1'b1;
    t = cyc;
    push(3'd4, t + 7);
    wait_to(t + 3);
    check("rerun_running", running, 1);
    wait_to(t + 6);
    run = 1'b0;
    wait_to(t + 9);
    check("pause_running", running, 0);
    step(10);
    check("pause_sb_empty", sb.size(), 0);
    check("pause_selc", selc, 4);
    t = cyc;
    run = 1'b1;
    push(3'd3, t + 7);
    wait_to(t + 8);
    check("resume_sb_empty", sb.size(), 0);
    check("resume_selc", selc, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
